// File: rtl/cook_timer_pkg.sv
// Shared types and constants for the cook timer: FSM state codes, BCD wrap limits,
// the default alarm length and a single-digit BCD decrement helper.
package cook_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [3:0] BCD_UNITS_MAX  = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX   = 4'd5;
  localparam int         DONE_TICKS_DEF = 3;

  // A zero digit wraps to the given limit; the caller propagates the borrow.
  function automatic logic [3:0] bcd_dec(input logic [3:0] d, input logic [3:0] wrap);
    return (d == 4'd0) ? wrap : d - 4'd1;
  endfunction

endpackage

// File: rtl/mmss_down_counter.sv
// MM:SS time register made of four BCD digits: clear, keypad shift-in,
// seconds-tens clamp and a cascaded one-second down-count.
module mmss_down_counter
  import cook_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [3:0]  shift_digit,
  input  logic        clamp_en,
  input  logic        dec_en,
  output logic [15:0] digits,
  output logic        is_zero,
  output logic        is_one
);

  logic [3:0] sec_u, sec_t, min_u, min_t;

  assign digits  = {min_t, min_u, sec_t, sec_u};
  assign is_zero = (digits == 16'h0000);
  assign is_one  = (digits == 16'h0001);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sec_u <= 4'd0;
      sec_t <= 4'd0;
      min_u <= 4'd0;
      min_t <= 4'd0;
    end else if (clr) begin
      sec_u <= 4'd0;
      sec_t <= 4'd0;
      min_u <= 4'd0;
      min_t <= 4'd0;
    end else if (clamp_en) begin
      if (sec_t > BCD_TENS_MAX) sec_t <= BCD_TENS_MAX;
    end else if (shift_en) begin
      min_t <= min_u;
      min_u <= sec_t;
      sec_t <= sec_u;
      sec_u <= shift_digit;
    end else if (dec_en) begin
      sec_u <= bcd_dec(sec_u, BCD_UNITS_MAX);
      if (sec_u == 4'd0) begin
        sec_t <= bcd_dec(sec_t, BCD_TENS_MAX);
        if (sec_t == 4'd0) begin
          min_u <= bcd_dec(min_u, BCD_UNITS_MAX);
          if (min_u == 4'd0) min_t <= bcd_dec(min_t, BCD_UNITS_MAX);
        end
      end
    end
  end

endmodule

// File: rtl/cook_timer_ctrl.sv
// Microwave cook timer controller: keypad entry, BCD countdown and end alarm.
// Optional door interlock is enabled by defining DOOR_INTERLOCK_EN.
//
//   state | meaning
//   IDLE  | time cleared, waiting for first key
//   ENTRY | keypad digits being shifted in
//   COOK  | magnetron on, counting down on tick
//   PAUSE | magnetron off, time held
//   DONE  | alarm on for DONE_TICKS ticks
module cook_timer_ctrl
  import cook_timer_pkg::*;
#(
  parameter int DONE_TICKS = DONE_TICKS_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tick,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop_clear,
  input  logic        door_open,
  output logic [15:0] digits,
  output logic        magnetron,
  output logic        done,
  output logic [2:0]  state
);

  localparam int DCW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;

  state_e         state_q;
  logic [DCW-1:0] done_cnt;
  logic           door_block;
  logic           key_ok, start_ok;
  logic           ev_clr, ev_shift, ev_clamp, ev_go, ev_pause, ev_dec;
  logic           is_zero, is_one;

`ifdef DOOR_INTERLOCK_EN
  assign door_block = door_open;
`else
  assign door_block = 1'b0;
  logic unused_door;
  assign unused_door = door_open;
`endif

  assign key_ok   = key_valid && (key_digit <= BCD_UNITS_MAX);
  assign start_ok = start && !door_block;
  assign state    = state_q;

  // Ignored strobes behave as absent, so a lower-priority input may act instead.
  always_comb begin
    ev_clr   = 1'b0;
    ev_shift = 1'b0;
    ev_clamp = 1'b0;
    ev_go    = 1'b0;
    ev_pause = 1'b0;
    ev_dec   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (stop_clear)  ev_clr   = 1'b1;
        else if (key_ok) ev_shift = 1'b1;
      end
      ST_ENTRY: begin
        if (stop_clear) ev_clr = 1'b1;
        else if (start_ok && !is_zero) begin
          ev_go    = 1'b1;
          ev_clamp = 1'b1;
        end else if (key_ok) ev_shift = 1'b1;
      end
      ST_COOK: begin
        if (stop_clear || door_block) ev_pause = 1'b1;
        else if (tick && !is_zero)    ev_dec   = 1'b1;
      end
      ST_PAUSE: begin
        if (stop_clear)    ev_clr = 1'b1;
        else if (start_ok) ev_go  = 1'b1;
      end
      ST_DONE: ev_clr = stop_clear;
      default: ev_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      magnetron <= 1'b0;
      done      <= 1'b0;
      done_cnt  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (ev_shift) state_q <= ST_ENTRY;
        ST_ENTRY: begin
          if (ev_clr) state_q <= ST_IDLE;
          else if (ev_go) begin
            state_q   <= ST_COOK;
            magnetron <= 1'b1;
          end
        end
        ST_COOK: begin
          if (ev_pause) begin
            state_q   <= ST_PAUSE;
            magnetron <= 1'b0;
          end else if (ev_dec && is_one) begin
            state_q   <= ST_DONE;
            magnetron <= 1'b0;
            done      <= 1'b1;
            done_cnt  <= DCW'(DONE_TICKS - 1);
          end
        end
        ST_PAUSE: begin
          if (ev_clr) state_q <= ST_IDLE;
          else if (ev_go) begin
            state_q   <= ST_COOK;
            magnetron <= 1'b1;
          end
        end
        ST_DONE: begin
          if (stop_clear) begin
            state_q <= ST_IDLE;
            done    <= 1'b0;
          end else if (tick) begin
            if (done_cnt == '0) begin
              state_q <= ST_IDLE;
              done    <= 1'b0;
            end else begin
              done_cnt <= done_cnt - 1'b1;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          magnetron <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  mmss_down_counter u_mmss (
    .clk         (clk),
    .rstn        (rstn),
    .clr         (ev_clr),
    .shift_en    (ev_shift),
    .shift_digit (key_digit),
    .clamp_en    (ev_clamp),
    .dec_en      (ev_dec),
    .digits      (digits),
    .is_zero     (is_zero),
    .is_one      (is_one)
  );

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Directed bench for cook_timer_ctrl: entry, countdown, pause, alarm, reset and door paths.
module tb_cook_timer_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        tick = 1'b0, key_valid = 1'b0, start = 1'b0, stop_clear = 1'b0, door_open = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic [15:0] digits;
  logic        magnetron, done;
  logic [2:0]  state;
  int          checks = 0;
  int          failures = 0;

  cook_timer_ctrl #(.DONE_TICKS(3)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .tick       (tick),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .start      (start),
    .stop_clear (stop_clear),
    .door_open  (door_open),
    .digits     (digits),
    .magnetron  (magnetron),
    .done       (done),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given strobes, then sample 1 ns after the edge.
  task automatic cyc(input logic t, input logic kv, input logic [3:0] kd,
                     input logic st, input logic sc);
    tick = t; key_valid = kv; key_digit = kd; start = st; stop_clear = sc;
    @(posedge clk); #1;
    tick = 1'b0; key_valid = 1'b0; start = 1'b0; stop_clear = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);  cyc(1'b0, 1'b1, d, 1'b0, 1'b0); endtask
  task automatic go();                      cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0); endtask
  task automatic stp();                     cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1); endtask
  task automatic tk();                      cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0); endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_mag", 32'(magnetron), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rstn = 1'b1;
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // 1:30 countdown to the alarm
    key(4'd1);
    chk("key1_state", 32'(state), 32'd1);
    chk("key1_digits", 32'(digits), 32'h0001);
    key(4'd3);
    key(4'd0);
    chk("key130", 32'(digits), 32'h0130);
    go();
    chk("start_state", 32'(state), 32'd2);
    chk("start_mag", 32'(magnetron), 32'd1);
    chk("start_digits", 32'(digits), 32'h0130);
    for (int i = 1; i <= 90; i++) begin
      tk();
      if (i == 1)  chk("t1", 32'(digits), 32'h0129);
      if (i == 30) chk("t30", 32'(digits), 32'h0100);
      if (i == 31) chk("t31_minwrap", 32'(digits), 32'h0059);
      if (i == 89) begin
        chk("t89", 32'(digits), 32'h0001);
        chk("t89_state", 32'(state), 32'd2);
      end
    end
    chk("t90_digits", 32'(digits), 32'h0000);
    chk("t90_state", 32'(state), 32'd4);
    chk("t90_done", 32'(done), 32'd1);
    chk("t90_mag", 32'(magnetron), 32'd0);
    tk();
    tk();
    chk("done_after2", 32'(done), 32'd1);
    chk("done_after2_state", 32'(state), 32'd4);
    tk();
    chk("done_after3", 32'(done), 32'd0);
    chk("done_after3_state", 32'(state), 32'd0);

    // Clamp, pause priority, resume, clear
    key(4'd9);
    key(4'd9);
    chk("key99", 32'(digits), 32'h0099);
    go();
    chk("clamp", 32'(digits), 32'h0059);
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("pause_state", 32'(state), 32'd3);
    chk("pause_digits", 32'(digits), 32'h0059);
    chk("pause_mag", 32'(magnetron), 32'd0);
    tk();
    chk("pause_tick_ign", 32'(digits), 32'h0059);
    go();
    chk("resume_state", 32'(state), 32'd2);
    chk("resume_mag", 32'(magnetron), 32'd1);
    tk();
    chk("resume_tick", 32'(digits), 32'h0058);
    stp();
    stp();
    chk("clear_state", 32'(state), 32'd0);
    chk("clear_digits", 32'(digits), 32'h0000);

    // Invalid key, zero start, minute borrow, ignored strobes in COOK
    key(4'd12);
    chk("badkey_state", 32'(state), 32'd0);
    key(4'd0);
    chk("key0_state", 32'(state), 32'd1);
    go();
    chk("zero_start", 32'(state), 32'd1);
    key(4'd1);
    key(4'd0);
    key(4'd0);
    go();
    tk();
    chk("borrow_0100", 32'(digits), 32'h0059);
    go();
    chk("cook_start_ign", 32'(state), 32'd2);
    key(4'd5);
    chk("cook_key_ign", 32'(digits), 32'h0059);
    stp();
    stp();

    // Oldest digit discarded, clamp with minutes present
    key(4'd9); key(4'd8); key(4'd7); key(4'd6); key(4'd5);
    chk("shift5", 32'(digits), 32'h8765);
    go();
    chk("clamp_8765", 32'(digits), 32'h8755);
    tk();
    chk("dec_8755", 32'(digits), 32'h8754);
    stp();
    stp();

    // stop_clear during the alarm
    key(4'd1);
    go();
    tk();
    chk("short_done", 32'(state), 32'd4);
    stp();
    chk("done_stop_state", 32'(state), 32'd0);
    chk("done_stop_done", 32'(done), 32'd0);

    // Door switch
    key(4'd5);
    go();
    door_open = 1'b1;
`ifdef DOOR_INTERLOCK_EN
    tk();
    chk("door_pause", 32'(state), 32'd3);
    chk("door_mag", 32'(magnetron), 32'd0);
    chk("door_digits", 32'(digits), 32'h0005);
    go();
    chk("door_start_ign", 32'(state), 32'd3);
    door_open = 1'b0;
    go();
    chk("door_resume", 32'(state), 32'd2);
`else
    tk();
    chk("door_noeffect_state", 32'(state), 32'd2);
    chk("door_noeffect_digits", 32'(digits), 32'h0004);
    door_open = 1'b0;
`endif

    // Asynchronous reset mid-COOK
    chk("pre_rst_mag", 32'(magnetron), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async_mag", 32'(magnetron), 32'd0);
    chk("async_state", 32'(state), 32'd0);
    chk("async_digits", 32'(digits), 32'h0000);
    chk("async_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
